// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single pixel-write port of vga_adapter between two pixel
//   producers. It also contains a full-screen clear sequencer. At most one
//   plot pulse is issued per clock. Output registers have a latency of one
//   cycle.
//
// Parameters
//   SCREEN_WIDTH   pixels per row; accepted x at or above this is clipped
//   SCREEN_HEIGHT  rows;           accepted y at or above this is clipped
//
// Ports
//   CLOCK_50       system clock, rising edge
//   reset          asynchronous, active-high reset
//   clear_start    one-cycle request for a full-screen clear (ignored mid-clear)
//   clear_colour   fill colour, sampled when clear_start is accepted
//   clear_busy     high while the clear sequencer owns the output port
//   reqN_valid     requester N offers a pixel (held until reqN_ready)
//   reqN_x/y/colour requester N pixel
//   reqN_ready     requester N pixel accepted this cycle (combinational)
//   vga_x/y/colour pixel registered towards vga_adapter
//   vga_plot       one-cycle write strobe towards vga_adapter
//   clip_count     saturating count of accepted off-screen pixels
module vga_plot_arbiter #(
  parameter int unsigned SCREEN_WIDTH  = 160,
  parameter int unsigned SCREEN_HEIGHT = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic        clear_busy,
  input  logic        req0_valid,
  input  logic [7:0]  req0_x,
  input  logic [6:0]  req0_y,
  input  logic [2:0]  req0_colour,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_x,
  input  logic [6:0]  req1_y,
  input  logic [2:0]  req1_colour,
  output logic        req1_ready,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [15:0] clip_count
);

  localparam logic [8:0] X_LIM  = 9'(SCREEN_WIDTH);
  localparam logic [7:0] Y_LIM  = 8'(SCREEN_HEIGHT);
  localparam logic [7:0] X_LAST = 8'(SCREEN_WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_HEIGHT - 1);

  typedef enum logic {
    SERVE,
    CLEAR
  } state_t;

  state_t      state;
  state_t      state_next;

  // 1 when requester 1 was served last; reset to 1 so requester 0 wins the
  // first tie.
  logic        last_grant;

  logic [7:0]  cx;
  logic [6:0]  cy;
  logic [2:0]  fill_colour;

  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_colour;
  logic        on_screen;
  logic        last_pixel;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= SERVE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and arbitration
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    unique case (state)
      SERVE: begin
        // Round robin on a tie: the requester not served last wins.
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        if (clear_start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (last_pixel) begin
          state_next = SERVE;
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign clear_busy = (state == CLEAR);

  assign xfer       = grant0 || grant1;
  assign sel_x      = grant0 ? req0_x      : req1_x;
  assign sel_y      = grant0 ? req0_y      : req1_y;
  assign sel_colour = grant0 ? req0_colour : req1_colour;
  assign on_screen  = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign last_pixel = (cx == X_LAST) && (cy == Y_LAST);

  // Output port, clear scan counters, fairness pointer and clip counter
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      last_grant  <= 1'b1;
      cx          <= '0;
      cy          <= '0;
      fill_colour <= '0;
      clip_count  <= '0;
    end else begin
      vga_plot <= 1'b0;
      if (state == CLEAR) begin
        vga_x      <= cx;
        vga_y      <= cy;
        vga_colour <= fill_colour;
        vga_plot   <= 1'b1;
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? '0 : cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end else begin
        if (xfer) begin
          // Off-screen pixels are still registered and accepted, but never
          // strobed into the frame buffer.
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_colour;
          vga_plot   <= on_screen;
          last_grant <= grant1;
          if (!on_screen && (clip_count != '1)) begin
            clip_count <= clip_count + 16'd1;
          end
        end
        // A transfer in the same cycle still completes; the scan starts at
        // the origin on the next cycle.
        if (clear_start) begin
          fill_colour <= clear_colour;
          cx          <= '0;
          cy          <= '0;
        end
      end
    end
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) between two pixel-producing engines, e.g. a circle drawer and a line drawer.
- Also contains a built-in full-screen clear sequencer that fills every pixel with one colour.
- Sits between the drawing engines and vga_adapter, and guarantees at most one plot per clock.

Parameters:
- SCREEN_WIDTH, 160, pixels per row; the clip limit for x.
- SCREEN_HEIGHT, 120, rows; the clip limit for y.

Ports:
- CLOCK_50  in  1  system clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_start  in  1  one-cycle pulse that requests a full-screen clear.
- clear_colour  in  3  fill colour; sampled in the cycle clear_start is accepted.
- clear_busy  out  1  high while a clear is in progress.
- req0_valid  in  1  requester 0 offers a pixel.
- req0_x  in  8  requester 0 x coordinate.
- req0_y  in  7  requester 0 y coordinate.
- req0_colour  in  3  requester 0 colour.
- req0_ready  out  1  requester 0 pixel accepted this cycle.
- req1_valid, req1_x, req1_y, req1_colour, req1_ready: same as requester 0, for requester 1.
- vga_x  out  8  to vga_adapter x.
- vga_y  out  7  to vga_adapter y.
- vga_colour  out  3  to vga_adapter colour.
- vga_plot  out  1  to vga_adapter plot.
- clip_count  out  16  number of accepted pixels that were off-screen; saturates.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state SERVE;
  - vga_x, vga_y, vga_colour, vga_plot = 0;
  - clear_busy = 0, clip_count = 0;
  - clear counters = 0;
  - last_grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-clear aborts the clear immediately; no further plot pulses are issued.
- States: SERVE and CLEAR.
- SERVE, arbitration:
  - req0_ready and req1_ready are combinational; at most one is high per cycle.
  - Only one requester valid: that requester gets ready.
  - Both valid: round-robin; the requester not equal to last_grant gets ready.
  - A transfer is valid && ready. On a transfer, last_grant is updated to the served requester.
  - No valid requester: both ready signals low, last_grant unchanged.
  - A requester holds valid and its data stable until it sees ready; the arbiter never drops a held request.
- SERVE, output (latency 1):
  - A transfer in cycle t registers x, y and colour onto vga_x, vga_y, vga_colour in cycle t+1.
  - vga_plot = 1 for exactly that one cycle, provided x < SCREEN_WIDTH and y < SCREEN_HEIGHT.
- Clipping:
  - A transfer with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT is still accepted (ready high).
  - vga_plot stays 0 in t+1.
  - clip_count increments by 1 and saturates at 16'hFFFF.
- Cycles with no transfer give vga_plot = 0; vga_x, vga_y and vga_colour hold their last values.
- SERVE to CLEAR:
  - clear_start = 1 in SERVE latches clear_colour, resets cx = 0 and cy = 0, and moves to CLEAR next cycle.
  - A requester transfer in that same cycle still completes normally: its pixel appears in t+1, and clear pixels begin in t+2.
- CLEAR:
  - req0_ready = req1_ready = 0. clear_busy = 1 from the first CLEAR cycle through the cycle that registers the last clear pixel.
  - Each cycle registers vga_x = cx, vga_y = cy, vga_colour = latched colour, vga_plot = 1. This gives a continuous run of SCREEN_WIDTH*SCREEN_HEIGHT plot pulses (19200 at defaults).
  - Scan order is x inner, y outer: cx increments and wraps from SCREEN_WIDTH-1 to 0, at which point cy increments.
  - After the pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) is registered, return to SERVE; clear_busy drops the next cycle.
  - clear_start during CLEAR is ignored; no queueing and no restart.
- Width rules:
  - Coordinate compares are unsigned at the port widths.
  - cx is 8 bits and cy is 7 bits; they never exceed their limits.

Test Plan:
- After reset, req0 only, pixel (10,20,3'b110) valid for 1 cycle -> req0_ready=1 that cycle; next cycle vga_plot=1 with vga_x=10, vga_y=20, vga_colour=6; vga_plot=0 the cycle after.
- req0 and req1 both held valid for 4 cycles from reset -> grants alternate 0,1,0,1; four consecutive plot pulses in that order; neither requester is starved.
- req1 pixel (200,5) -> accepted (req1_ready=1), vga_plot stays 0, clip_count=1. Repeat 65536 clipped pixels -> clip_count holds 16'hFFFF.
- clear_start with clear_colour=3'b001 -> clear_busy high; exactly 19200 consecutive plot pulses; first at (0,0), 160th at (159,0), last at (159,119), all colour 1; requester readies low throughout; SERVE resumes and a waiting req0 is granted on the first cycle after clear_busy falls.
- clear_start in the same cycle as a req0 transfer (5,5) -> (5,5) plotted in t+1, clear pixel (0,0) in t+2. A second clear_start mid-clear -> total pulses still 19200.
- Assert reset after 500 clear pixels -> vga_plot=0 and clear_busy=0 immediately (asynchronous); after release, req0 is served normally with no residual clear pixels.
